fib_stack_engine: RTL and testbench

//   Self-contained recursive Fibonacci engine with an embedded controller FSM.

---
 rtl/fib_stack_engine_if.sv | 33 +++
 rtl/fib_stack_engine.sv | 154 +++++++++++++++
 tb/tb_fib_stack_engine.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fib_stack_engine_if.sv
// Handshake and result bundle for the recursive Fibonacci engine.
// The master side drives start/n_in; the slave side (the engine) drives the rest.
// fsm_state mirrors the engine's controller state for debug and checkers.
interface fib_stack_engine_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int SPW = $clog2(DEPTH + 1);

  // Handshake: start is a request sampled only while the engine is idle
  // (busy=0). busy rises the cycle after an accepted start and stays high
  // until done. done is a single-cycle pulse marking result, ovf, stk_err
  // and max_sp as valid; all of them then hold until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] n_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             stk_err;
  logic [SPW-1:0]   max_sp;
  logic [2:0]       fsm_state;

  modport master (
    output start, n_in,
    input  busy, done, result, ovf, stk_err, max_sp, fsm_state
  );

  modport slave (
    input  start, n_in,
    output busy, done, result, ovf, stk_err, max_sp, fsm_state
  );
endinterface

// File: rtl/fib_stack_engine.sv
// Recursive Fibonacci engine: evaluates fib(n) = fib(n-1) + fib(n-2) by
// walking the call tree with an explicit frame stack. Each frame holds
// {n, phase, partial sum}; phase 0 means fib(n-1) is still pending, phase 1
// means fib(n-1) is stored in the frame and fib(n-2) is being computed.
module fib_stack_engine #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  fib_stack_engine_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW  = 2 * WIDTH + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_RETURN = 3'd2;
  localparam logic [2:0] S_RESUME = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] ret;
  logic [WIDTH-1:0] res;
  logic             ph;
  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             stk_err_q;
  logic [SPW-1:0]   max_sp_q;

  logic [FW-1:0]    stack [DEPTH];

  logic             push_en;
  logic [FW-1:0]    push_data;
  logic [SPW-1:0]   sp_inc;
  logic [SPW-1:0]   sp_dec;
  logic [WIDTH:0]   sum;
  logic             n_small;
  logic             stk_full;

  assign sp_inc   = sp + SPW'(1);
  assign sp_dec   = sp - SPW'(1);
  assign sum      = {1'b0, res} + {1'b0, ret};
  assign n_small  = (n < WIDTH'(2));
  assign stk_full = (sp == SPW'(DEPTH));

  // Push decode: descend into fib(n-1) from CHECK, or into fib(n-2) from RESUME.
  always_comb begin
    push_en   = 1'b0;
    push_data = '0;
    if (state == S_CHECK && !n_small && !stk_full) begin
      push_en   = 1'b1;
      push_data = {n, 1'b0, {WIDTH{1'b0}}};
    end else if (state == S_RESUME && !ph) begin
      push_en   = 1'b1;
      push_data = {n, 1'b1, ret};
    end
  end

  // Frame storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack[sp[AW-1:0]] <= push_data;
    end
  end

  // Controller FSM and datapath registers; every state lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      n         <= '0;
      ret       <= '0;
      res       <= '0;
      ph        <= 1'b0;
      sp        <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      stk_err_q <= 1'b0;
      max_sp_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            n         <= bus.n_in;
            ret       <= '0;
            sp        <= '0;
            ovf_q     <= 1'b0;
            stk_err_q <= 1'b0;
            max_sp_q  <= '0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (n_small) begin
            ret   <= n;
            state <= S_RETURN;
          end else if (stk_full) begin
            // Abort: the result of a truncated recursion is meaningless.
            stk_err_q <= 1'b1;
            result_q  <= '0;
            state     <= S_DONE;
          end else begin
            sp <= sp_inc;
            n  <= n - WIDTH'(1);
            if (sp_inc > max_sp_q) begin
              max_sp_q <= sp_inc;
            end
          end
        end
        S_RETURN: begin
          if (sp == '0) begin
            result_q <= ret;
            state    <= S_DONE;
          end else begin
            {n, ph, res} <= stack[sp_dec[AW-1:0]];
            sp           <= sp_dec;
            state        <= S_RESUME;
          end
        end
        S_RESUME: begin
          if (!ph) begin
            // Re-uses the slot freed by the preceding pop, so it always fits.
            sp    <= sp_inc;
            n     <= n - WIDTH'(2);
            state <= S_CHECK;
          end else begin
            ret <= sum[WIDTH-1:0];
            if (sum[WIDTH]) begin
              ovf_q <= 1'b1;
            end
            state <= S_RETURN;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.stk_err   = stk_err_q;
  assign bus.max_sp    = max_sp_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_fib_stack_engine.sv
// Bench for fib_stack_engine: a default instance (DEPTH=16) and a shallow
// instance (DEPTH=4) share clock and reset. A behavioural model predicts
// each run's result, flags, stack depth and cycle count from fib arithmetic.
module tb_fib_stack_engine;
  logic clk;
  logic rst;

  fib_stack_engine_if #(.WIDTH(8), .DEPTH(16)) bus_a ();
  fib_stack_engine_if #(.WIDTH(8), .DEPTH(4))  bus_b ();

  fib_stack_engine #(.WIDTH(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fib_stack_engine #(.WIDTH(8), .DEPTH(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // Whole-run prediction from fib arithmetic and a closed-form cycle count:
  // T(0)=T(1)=1, T(n)=5+T(n-1)+T(n-2); run length = T(n)+2 (final RETURN, DONE).
  task automatic model_run(input int n, input int depth, output int res, output int ovf,
                           output int serr, output int msp, output int cycles);
    int a, b, s;
    int t [0:255];
    if (n - 1 > depth) begin
      res = 0; ovf = 0; serr = 1; msp = depth; cycles = depth + 2;
    end else begin
      a = 0; b = 1; ovf = 0;
      for (int k = 2; k <= n; k++) begin
        s = a + b;
        if (s > 255) ovf = 1;
        s = s & 255;
        a = b;
        b = s;
      end
      res  = (n == 0) ? 0 : b;
      serr = 0;
      msp  = (n > 0) ? n - 1 : 0;
      t[0] = 1; t[1] = 1;
      for (int k = 2; k <= n; k++) t[k] = 5 + t[k-1] + t[k-2];
      cycles = t[n] + 2;
    end
  endtask

  int rem    [2];
  int e_res  [2];
  int e_ovf  [2];
  int e_serr [2];
  int e_msp  [2];
  int p_res  [2];
  int p_ovf  [2];
  int p_serr [2];
  int p_msp  [2];

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int st, nv, dp, r, o, se, ms, cy;
      st = (i == 0) ? int'(bus_a.start) : int'(bus_b.start);
      nv = (i == 0) ? int'(bus_a.n_in)  : int'(bus_b.n_in);
      dp = (i == 0) ? 16 : 4;
      if (rst) begin
        rem[i] <= 0; e_res[i] <= 0; e_ovf[i] <= 0; e_serr[i] <= 0; e_msp[i] <= 0;
      end else if (rem[i] == 0) begin
        if (st != 0) begin
          model_run(nv, dp, r, o, se, ms, cy);
          rem[i] <= cy;
          p_res[i] <= r; p_ovf[i] <= o; p_serr[i] <= se; p_msp[i] <= ms;
          e_ovf[i] <= 0; e_serr[i] <= 0; e_msp[i] <= 0;
        end
      end else begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 2) begin
          e_res[i] <= p_res[i]; e_ovf[i] <= p_ovf[i];
          e_serr[i] <= p_serr[i]; e_msp[i] <= p_msp[i];
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("a_busy",   32'(bus_a.busy),   32'(rem[0] > 0));
    chk("a_done",   32'(bus_a.done),   32'(rem[0] == 1));
    chk("a_result", 32'(bus_a.result), 32'(e_res[0]));
    if (rem[0] <= 1) begin
      chk("a_ovf",     32'(bus_a.ovf),     32'(e_ovf[0]));
      chk("a_stk_err", 32'(bus_a.stk_err), 32'(e_serr[0]));
      chk("a_max_sp",  32'(bus_a.max_sp),  32'(e_msp[0]));
    end
    chk("b_busy",   32'(bus_b.busy),   32'(rem[1] > 0));
    chk("b_done",   32'(bus_b.done),   32'(rem[1] == 1));
    chk("b_result", 32'(bus_b.result), 32'(e_res[1]));
    if (rem[1] <= 1) begin
      chk("b_ovf",     32'(bus_b.ovf),     32'(e_ovf[1]));
      chk("b_stk_err", 32'(bus_b.stk_err), 32'(e_serr[1]));
      chk("b_max_sp",  32'(bus_b.max_sp),  32'(e_msp[1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input int which, input int n);
    @(negedge clk);
    if (which == 0) begin bus_a.n_in = 8'(n); bus_a.start = 1'b1; end
    else            begin bus_b.n_in = 8'(n); bus_b.start = 1'b1; end
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  // Waits for done; cnt = negedges after the first busy cycle.
  task automatic wait_done(input int which, output int cnt);
    cnt = 0;
    while (((which == 0) ? bus_a.done : bus_b.done) !== 1'b1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 20000) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done expected done within 20000 cycles");
    end
  endtask

  task automatic run_a(input int n, output int cnt);
    start_run(0, n);
    wait_done(0, cnt);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    int r, o, se, ms, cy;
    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.n_in = '0;
    bus_b.start = 1'b0; bus_b.n_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus_a.busy),   0);
    chk("rst_result", 32'(bus_a.result), 0);
    rst = 1'b0;

    // Model pins against hand-computed values.
    model_run(10, 16, r, o, se, ms, cy);
    chk("model_fib10", 32'(r), 55);
    chk("model_msp10", 32'(ms), 9);
    model_run(14, 16, r, o, se, ms, cy);
    chk("model_fib14", 32'(r), 121);
    chk("model_ovf14", 32'(o), 1);
    model_run(1, 16, r, o, se, ms, cy);
    chk("model_cyc1", 32'(cy), 3);

    // Base cases and latency.
    run_a(0, cnt);
    chk("lit_n0_res", 32'(bus_a.result), 0);
    chk("lit_n0_lat", 32'(cnt), 2);
    run_a(1, cnt);
    chk("lit_n1_res", 32'(bus_a.result), 1);
    chk("lit_n1_lat", 32'(cnt), 2);
    chk("lit_n1_msp", 32'(bus_a.max_sp), 0);

    // Typical run and overflow boundary.
    run_a(10, cnt);
    chk("lit_n10_res", 32'(bus_a.result), 55);
    chk("lit_n10_msp", 32'(bus_a.max_sp), 9);
    run_a(13, cnt);
    chk("lit_n13_res", 32'(bus_a.result), 233);
    chk("lit_n13_ovf", 32'(bus_a.ovf), 0);
    run_a(14, cnt);
    chk("lit_n14_res", 32'(bus_a.result), 121);
    chk("lit_n14_ovf", 32'(bus_a.ovf), 1);

    // Stack limit on the shallow instance.
    start_run(1, 5);
    wait_done(1, cnt);
    chk("lit_b5_res", 32'(bus_b.result), 5);
    chk("lit_b5_msp", 32'(bus_b.max_sp), 4);
    start_run(1, 6);
    wait_done(1, cnt);
    chk("lit_b6_err", 32'(bus_b.stk_err), 1);
    chk("lit_b6_res", 32'(bus_b.result), 0);

    // Reset mid-run, then recovery.
    start_run(0, 12);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_rst_busy", 32'(bus_a.busy), 0);
    chk("lit_rst_res",  32'(bus_a.result), 0);
    run_a(7, cnt);
    chk("lit_n7_res", 32'(bus_a.result), 13);

    // start held high for the whole run: exactly one computation.
    @(negedge clk);
    bus_a.n_in = 8'd8;
    bus_a.start = 1'b1;
    @(negedge clk);
    wait_done(0, cnt);
    bus_a.start = 1'b0;
    chk("lit_n8_res", 32'(bus_a.result), 21);
    repeat (2) @(negedge clk);
    chk("lit_n8_idle", 32'(bus_a.busy), 0);

    // Randomised runs on both instances.
    for (int i = 0; i < 20; i++) begin
      run_a(int'($urandom_range(0, 14)), cnt);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      start_run(1, int'($urandom_range(0, 7)));
      wait_done(1, cnt);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
